// File: rtl/bias_pe_pkg.sv
// Shared types for the bias PE: fixed-point format, sequencer states and a
// saturating narrow helper used when BIAS_PE_SAT_EN is defined.
package bias_pe_pkg;

    localparam int FIXED_W       = 16;
    localparam int FRAC_BITS_DEF = 8;

    typedef logic signed [FIXED_W-1:0] fixed_16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Returns {clamped, value}: the value clamped into the signed 16-bit range.
    function automatic logic [FIXED_W:0] sat16(input logic signed [32:0] v);
        if (v > 33'sd32767) begin
            return {1'b1, 16'h7FFF};
        end else if (v < -33'sd32768) begin
            return {1'b1, 16'h8000};
        end else begin
            return {1'b0, v[15:0]};
        end
    endfunction

endpackage

// File: rtl/bias_pe_sched_if.sv
// Stream bundle for the bias PE: upstream (sum, delta) beats and downstream net sums.
interface bias_pe_sched_if #(
    parameter int IDX_W = 4
);
    import bias_pe_pkg::*;

    // Both streams: a beat transfers on a rising clock edge where valid && ready;
    // valid never depends on ready, and payload is stable while valid && !ready.
    logic             in_valid;
    logic             in_ready;
    fixed_16          in_sum;
    fixed_16          in_delta;
    logic             out_valid;
    logic             out_ready;
    fixed_16          out_net_sum;
    logic [IDX_W-1:0] out_idx;

    modport master (
        output in_valid, in_sum, in_delta, out_ready,
        input  in_ready, out_valid, out_net_sum, out_idx
    );

    modport slave (
        input  in_valid, in_sum, in_delta, out_ready,
        output in_ready, out_valid, out_net_sum, out_idx
    );

endinterface

// File: rtl/bias_pe_alu.sv
// Combinational bias datapath: net_sum = bias + sum, bias update = bias - (delta*eta >>> FRAC_BITS).
// With BIAS_PE_SAT_EN defined every result clamps instead of wrapping and clamp flags are reported.
module bias_pe_alu
    import bias_pe_pkg::*;
#(
    parameter int FRAC_BITS = FRAC_BITS_DEF
) (
    input  fixed_16 bias,
    input  fixed_16 sum_in,
    input  fixed_16 delta,
    input  fixed_16 eta,
`ifdef BIAS_PE_SAT_EN
    output logic    sat_net,
    output logic    sat_upd,
`endif
    output fixed_16 net_sum,
    output fixed_16 new_bias
);

    logic signed [31:0] prod;
    fixed_16            step;

`ifdef BIAS_PE_SAT_EN
    logic [FIXED_W:0] net_r;
    logic [FIXED_W:0] step_r;
    logic [FIXED_W:0] upd_r;

    always_comb begin
        prod     = 32'(delta) * 32'(eta);
        step_r   = sat16(33'(prod >>> FRAC_BITS));
        step     = step_r[FIXED_W-1:0];
        net_r    = sat16(33'(bias) + 33'(sum_in));
        upd_r    = sat16(33'(bias) - 33'(step));
        net_sum  = net_r[FIXED_W-1:0];
        new_bias = upd_r[FIXED_W-1:0];
        sat_net  = net_r[FIXED_W];
        // A clamped step counts even if the subtraction itself stays in range.
        sat_upd  = step_r[FIXED_W] | upd_r[FIXED_W];
    end
`else
    always_comb begin
        prod     = 32'(delta) * 32'(eta);
        step     = FIXED_W'(prod >>> FRAC_BITS);
        net_sum  = bias + sum_in;
        new_bias = bias - step;
    end
`endif

endmodule

// File: rtl/bias_pe_sched.sv
// Bias PE sequencer: owns the bias file, walks neurons 0..NUM_NEURONS-1 per run and
// emits net sums with optional training write-back. Optional saturation: BIAS_PE_SAT_EN.
module bias_pe_sched
    import bias_pe_pkg::*;
#(
    parameter int NUM_NEURONS = 16,
    parameter int FRAC_BITS   = FRAC_BITS_DEF,
    parameter int IDX_W       = $clog2(NUM_NEURONS)
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             ap_ce,
    input  logic             ap_start,
    output logic             ap_idle,
    output logic             ap_done,
    input  logic             training,
    input  fixed_16          eta,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_addr,
    input  fixed_16          cfg_wdata,
    output fixed_16          cfg_rdata,
    bias_pe_sched_if.slave   strm,
    output state_e           dbg_state
`ifdef BIAS_PE_SAT_EN
    ,
    output logic             sat_seen
`endif
);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] k_q, k_d;
    fixed_16          eta_q, eta_d;
    logic             training_q, training_d;
    logic             out_valid_q, out_valid_d;
    fixed_16          out_net_sum_q, out_net_sum_d;
    logic [IDX_W-1:0] out_idx_q, out_idx_d;
    logic             ap_done_q, ap_done_d;
    fixed_16          bias_q [NUM_NEURONS];
    fixed_16          bias_d [NUM_NEURONS];

    logic    in_ready_w;
    logic    accept;
    logic    out_fire;
    fixed_16 alu_net_sum;
    fixed_16 alu_new_bias;

`ifdef BIAS_PE_SAT_EN
    logic sat_seen_q, sat_seen_d;
    logic alu_sat_net;
    logic alu_sat_upd;
`endif

    bias_pe_alu #(
        .FRAC_BITS (FRAC_BITS)
    ) u_alu (
        .bias     (bias_q[k_q]),
        .sum_in   (strm.in_sum),
        .delta    (strm.in_delta),
        .eta      (eta_q),
`ifdef BIAS_PE_SAT_EN
        .sat_net  (alu_sat_net),
        .sat_upd  (alu_sat_upd),
`endif
        .net_sum  (alu_net_sum),
        .new_bias (alu_new_bias)
    );

    // Output slot frees when its beat leaves, so a new beat can enter the same cycle.
    assign in_ready_w = ap_ce && (state_q == RUN) && (!out_valid_q || strm.out_ready);
    assign accept     = strm.in_valid && in_ready_w;
    assign out_fire   = out_valid_q && strm.out_ready;

    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        eta_d         = eta_q;
        training_d    = training_q;
        out_valid_d   = out_valid_q;
        out_net_sum_d = out_net_sum_q;
        out_idx_d     = out_idx_q;
        ap_done_d     = 1'b0;
        bias_d        = bias_q;
`ifdef BIAS_PE_SAT_EN
        sat_seen_d    = sat_seen_q;
`endif
        case (state_q)
            IDLE: begin
                if (cfg_we) begin
                    bias_d[cfg_addr] = cfg_wdata;
                end
                if (ap_start) begin
                    state_d    = RUN;
                    k_d        = '0;
                    eta_d      = eta;
                    training_d = training;
`ifdef BIAS_PE_SAT_EN
                    sat_seen_d = 1'b0;
`endif
                end
            end
            RUN: begin
                if (accept) begin
                    out_net_sum_d = alu_net_sum;
                    out_idx_d     = k_q;
                    out_valid_d   = 1'b1;
                    if (training_q) begin
                        bias_d[k_q] = alu_new_bias;
                    end
`ifdef BIAS_PE_SAT_EN
                    sat_seen_d = sat_seen_q | alu_sat_net | (training_q & alu_sat_upd);
`endif
                    k_d = k_q + 1'b1;
                    if (k_q == IDX_W'(NUM_NEURONS - 1)) begin
                        state_d = DRAIN;
                    end
                end else if (out_fire) begin
                    out_valid_d = 1'b0;
                end
            end
            DRAIN: begin
                if (out_fire) begin
                    out_valid_d = 1'b0;
                    state_d     = DONE;
                    ap_done_d   = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Clock enable low freezes everything, including an in-flight ap_done pulse.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q       <= IDLE;
            k_q           <= '0;
            eta_q         <= '0;
            training_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            out_net_sum_q <= '0;
            out_idx_q     <= '0;
            ap_done_q     <= 1'b0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                bias_q[i] <= '0;
            end
`ifdef BIAS_PE_SAT_EN
            sat_seen_q    <= 1'b0;
`endif
        end else if (ap_ce) begin
            state_q       <= state_d;
            k_q           <= k_d;
            eta_q         <= eta_d;
            training_q    <= training_d;
            out_valid_q   <= out_valid_d;
            out_net_sum_q <= out_net_sum_d;
            out_idx_q     <= out_idx_d;
            ap_done_q     <= ap_done_d;
            bias_q        <= bias_d;
`ifdef BIAS_PE_SAT_EN
            sat_seen_q    <= sat_seen_d;
`endif
        end
    end

    assign ap_idle          = (state_q == IDLE);
    assign ap_done          = ap_done_q;
    assign cfg_rdata        = bias_q[cfg_addr];
    assign dbg_state        = state_q;
    assign strm.in_ready    = in_ready_w;
    assign strm.out_valid   = out_valid_q;
    assign strm.out_net_sum = out_net_sum_q;
    assign strm.out_idx     = out_idx_q;
`ifdef BIAS_PE_SAT_EN
    assign sat_seen         = sat_seen_q;
`endif

endmodule

// File: tb/tb_bias_pe_sched.sv
// Self-checking bench for bias_pe_sched: directed vector table, stall / clock-enable /
// mid-run reset sequences and randomized runs against an arithmetic reference model.
module tb_bias_pe_sched;
    import bias_pe_pkg::*;

    localparam int N = 16;

    logic        clk = 1'b0;
    logic        rst_n, ce, start, training, cfg_we;
    logic [15:0] eta, cfg_wdata, cfg_rdata;
    logic [3:0]  cfg_addr;
    logic        ap_idle, ap_done;
    state_e      dbg_state;
`ifdef BIAS_PE_SAT_EN
    logic        sat_seen;
`endif

    bias_pe_sched_if #(.IDX_W(4)) bus ();

    bias_pe_sched #(.NUM_NEURONS(N)) dut (
        .ap_clk    (clk),
        .ap_rst_n  (rst_n),
        .ap_ce     (ce),
        .ap_start  (start),
        .ap_idle   (ap_idle),
        .ap_done   (ap_done),
        .training  (training),
        .eta       (eta),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .strm      (bus),
        .dbg_state (dbg_state)
`ifdef BIAS_PE_SAT_EN
        ,
        .sat_seen  (sat_seen)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- scoreboard / reference model ----------------
    int          n_checks = 0;
    int          n_err    = 0;
    logic [15:0] bias_m [N];
    logic [19:0] exp_q[$];
    bit          sat_m;
    logic [15:0] beat_sum [N];
    logic [15:0] beat_delta [N];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    function automatic int sx(input logic [15:0] v);
        return int'($signed(v));
    endfunction

    // Narrow an exact integer result to 16 bits: clamp when saturating, else wrap.
    function automatic logic [15:0] fit(input int v);
`ifdef BIAS_PE_SAT_EN
        if (v > 32767) begin
            sat_m = 1'b1;
            return 16'h7FFF;
        end
        if (v < -32768) begin
            sat_m = 1'b1;
            return 16'h8000;
        end
`endif
        return v[15:0];
    endfunction

    task automatic model_accept(input int k, input logic [15:0] s, input logic [15:0] d,
                                input bit tr, input logic [15:0] et);
        logic [15:0] net;
        logic [15:0] step;
        net = fit(sx(bias_m[k]) + sx(s));
        exp_q.push_back({k[3:0], net});
        if (tr) begin
            step      = fit((sx(d) * sx(et)) >>> 8);
            bias_m[k] = fit(sx(bias_m[k]) - sx(step));
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) bias_m[i] = 16'h0000;
        exp_q.delete();
    endtask

    task automatic write_bias(input int a, input logic [15:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = a[3:0];
        cfg_wdata = d;
        @(posedge clk);
        #1;
        cfg_we    = 1'b0;
        bias_m[a] = d;
    endtask

    task automatic readback_all(input string name);
        for (int i = 0; i < N; i++) begin
            cfg_addr = i[3:0];
            @(negedge clk);
            chk(name, cfg_rdata, bias_m[i]);
            @(posedge clk);
            #1;
        end
    endtask

    // One full run. stall_at / ce_at: after that many output handshakes, hold
    // out_ready low 5 cycles / ap_ce low 3 cycles with in_valid high.
    task automatic do_run(input bit tr, input logic [15:0] et, input int vpct, input int rpct,
                          input int stall_at, input int ce_at, input bit start_we,
                          output logic [15:0] first_net);
        int          acc, out_hs, last_hs, stall_cnt, ce_cnt;
        bit          stall_done, ce_done, finished, hold, frz_first;
        logic [15:0] snap_net;
        logic [3:0]  snap_idx;
        logic        snap_valid;
        logic [19:0] e;
        acc = 0; out_hs = 0; last_hs = -10; stall_cnt = 0; ce_cnt = 0;
        stall_done = 0; ce_done = 0; finished = 0; frz_first = 0;
        snap_net = '0; snap_idx = '0; snap_valid = 1'b0;
        first_net = 16'hDEAD;
        sat_m = 1'b0;
        start = 1'b1; training = tr; eta = et; ce = 1'b1;
        cfg_we = start_we; cfg_addr = 4'($urandom_range(0, N - 1)); cfg_wdata = 16'($urandom);
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        @(negedge clk);
        chk("idle_at_start", ap_idle, 1'b1);
        chk("rd_start", cfg_rdata, bias_m[cfg_addr]);
        if (start_we) bias_m[cfg_addr] = cfg_wdata;
        @(posedge clk);
        #1;
        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            hold          = (stall_cnt > 0) || (ce_cnt > 0);
            ce            = !(ce_cnt > 0);
            bus.out_ready = (stall_cnt > 0) ? 1'b0 : ($urandom_range(0, 99) < rpct);
            bus.in_valid  = (acc < N) && (hold || ($urandom_range(0, 99) < vpct));
            bus.in_sum    = (acc < N) ? beat_sum[acc] : 16'($urandom);
            bus.in_delta  = (acc < N) ? beat_delta[acc] : 16'($urandom);
            start         = ($urandom_range(0, 7) == 0);
            cfg_we        = ($urandom_range(0, 3) == 0);
            cfg_addr      = 4'($urandom_range(0, N - 1));
            cfg_wdata     = 16'($urandom);
            @(negedge clk);
            chk("rd_run", cfg_rdata, bias_m[cfg_addr]);
            if (hold) begin
                chk("frozen_in_ready", bus.in_ready, 1'b0);
                if (frz_first) begin
                    snap_net = bus.out_net_sum; snap_idx = bus.out_idx; snap_valid = bus.out_valid;
                    frz_first = 0;
                    if (stall_cnt > 0) chk("stall_out_valid", bus.out_valid, 1'b1);
                end else begin
                    chk("frozen_net", bus.out_net_sum, snap_net);
                    chk("frozen_idx", bus.out_idx, snap_idx);
                    chk("frozen_valid", bus.out_valid, snap_valid);
                end
            end
            if (ce) begin
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        fail("out_unexpected_beat");
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_idx", bus.out_idx, e[19:16]);
                        chk("out_net", bus.out_net_sum, e[15:0]);
                        if (e[19:16] == 4'd0) first_net = bus.out_net_sum;
                    end
                    out_hs++;
                    last_hs = cyc;
                end
                if (bus.in_valid && bus.in_ready) begin
                    model_accept(acc, bus.in_sum, bus.in_delta, tr, et);
                    acc++;
                end
                if (ap_done) begin
                    chk("done_latency", 16'(cyc), 16'(last_hs + 1));
                    chk("out_count", 16'(out_hs), 16'(N));
                    chk("exp_q_empty", 16'(exp_q.size()), 16'd0);
`ifdef BIAS_PE_SAT_EN
                    chk("sat_seen", sat_seen, sat_m);
`endif
                    finished = 1;
                end
            end
            if (stall_cnt > 0) stall_cnt--;
            if (ce_cnt > 0) ce_cnt--;
            if (stall_cnt == 0 && ce_cnt == 0) begin
                if (stall_at >= 0 && !stall_done && out_hs == stall_at) begin
                    stall_cnt = 5; stall_done = 1; frz_first = 1;
                end else if (ce_at >= 0 && !ce_done && out_hs == ce_at) begin
                    ce_cnt = 3; ce_done = 1; frz_first = 1;
                end
            end
            @(posedge clk);
            #1;
            if (finished) chk("idle_after_done", ap_idle, 1'b1);
        end
        start = 1'b0; cfg_we = 1'b0; ce = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        if (!finished) begin
            fail("run_timeout");
            do_reset();
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [15:0] bias, sum, delta, eta;
        bit          tr;
        logic [15:0] exp_net, exp_bias;
        bit          exp_sat;
    } vec_t;

`ifdef BIAS_PE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    vec_t vecs [8];

    initial begin : watchdog
        #3_000_000;
        $display("FAIL global_timeout");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
        $fatal(1, "bench timed out");
    end

    initial begin : main
        logic [15:0] fn;
        int          acc, dcount;
        vecs[0] = '{16'h0100, 16'h0080, 16'h0200, 16'h0040, 1'b1, 16'h0180, 16'h0080, 1'b0};
        vecs[1] = '{16'h0100, 16'h0080, 16'h0200, 16'h0040, 1'b0, 16'h0180, 16'h0100, 1'b0};
        vecs[2] = '{16'h7F00, 16'h0200, 16'h0000, 16'h0040, 1'b0,
                    SAT ? 16'h7FFF : 16'h8100, 16'h7F00, SAT};
        vecs[3] = '{16'h8000, 16'hFFFF, 16'h0000, 16'h0040, 1'b0,
                    SAT ? 16'h8000 : 16'h7FFF, 16'h8000, SAT};
        vecs[4] = '{16'h0000, 16'h1234, 16'h0100, 16'hFF00, 1'b1, 16'h1234, 16'h0100, 1'b0};
        vecs[5] = '{16'h7FFF, 16'h0000, 16'h0100, 16'hFF00, 1'b1,
                    16'h7FFF, SAT ? 16'h7FFF : 16'h80FF, SAT};
        vecs[6] = '{16'h0000, 16'h0001, 16'h7FFF, 16'h7FFF, 1'b1,
                    16'h0001, SAT ? 16'h8001 : 16'h0100, SAT};
        vecs[7] = '{16'h1000, 16'h0000, 16'h8000, 16'h8000, 1'b1,
                    16'h1000, SAT ? 16'h9001 : 16'h1000, SAT};

        rst_n = 1'b0; ce = 1'b1; start = 1'b0; training = 1'b0; eta = '0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        bus.in_valid = 1'b0; bus.in_sum = '0; bus.in_delta = '0; bus.out_ready = 1'b0;
        do_reset();

        // reset state
        @(negedge clk);
        chk("rst_idle", ap_idle, 1'b1);
        chk("rst_done", ap_done, 1'b0);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_net", bus.out_net_sum, 16'h0000);
        chk("rst_out_idx", bus.out_idx, 4'd0);
        chk("rst_state", dbg_state, IDLE);
        chk("rst_in_ready", bus.in_ready, 1'b0);
        @(posedge clk);
        #1;
        readback_all("rst_bias");

        // table-driven single-neuron arithmetic
        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < N; i++) begin
                beat_sum[i] = 16'h0000;
                beat_delta[i] = 16'h0000;
            end
            beat_sum[0]   = vecs[v].sum;
            beat_delta[0] = vecs[v].delta;
            write_bias(0, vecs[v].bias);
            do_run(vecs[v].tr, vecs[v].eta, 100, 100, -1, -1, 1'b0, fn);
            chk("vec_net", fn, vecs[v].exp_net);
            cfg_addr = 4'd0;
            @(negedge clk);
            chk("vec_bias", cfg_rdata, vecs[v].exp_bias);
`ifdef BIAS_PE_SAT_EN
            chk("vec_sat", sat_seen, vecs[v].exp_sat);
`endif
            @(posedge clk);
            #1;
        end
        readback_all("vec_bias_all");

        // downstream stall then clock-enable freeze, random data
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) begin
                write_bias(i, 16'($urandom));
                beat_sum[i]   = 16'($urandom);
                beat_delta[i] = 16'($urandom);
            end
            do_run(1'b1, 16'($urandom_range(0, 16'h00FF)), 100, 100,
                   (r == 0) ? 5 : -1, (r == 1) ? 6 : -1, 1'b0, fn);
            readback_all("freeze_bias");
        end

        // randomized back-to-back runs
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < N; i++) begin
                beat_sum[i]   = 16'($urandom);
                beat_delta[i] = 16'($urandom);
            end
            do_run(1'($urandom_range(0, 1)), 16'($urandom), $urandom_range(30, 100),
                   $urandom_range(30, 100), -1, -1, 1'($urandom_range(0, 1)), fn);
        end
        readback_all("rand_bias");

        // reset in the middle of a run, after seven accepts
        for (int i = 0; i < N; i++) write_bias(i, 16'($urandom) | 16'h0001);
        start = 1'b1; training = 1'b1; eta = 16'h0040;
        @(posedge clk);
        #1;
        start = 1'b0;
        acc = 0;
        for (int c = 0; c < 100 && acc < 7; c++) begin
            bus.in_valid = 1'b1; bus.in_sum = 16'($urandom); bus.in_delta = 16'($urandom);
            bus.out_ready = 1'b1;
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) acc++;
            @(posedge clk);
            #1;
        end
        chk("rst_mid_accepts", 16'(acc), 16'd7);
        rst_n = 1'b0; bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) bias_m[i] = 16'h0000;
        exp_q.delete();
        @(negedge clk);
        chk("rst_mid_idle", ap_idle, 1'b1);
        chk("rst_mid_out_valid", bus.out_valid, 1'b0);
        chk("rst_mid_state", dbg_state, IDLE);
        dcount = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (ap_done) dcount++;
        end
        chk("rst_mid_no_done", 16'(dcount), 16'd0);
        @(posedge clk);
        #1;
        readback_all("rst_mid_bias");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
